// File: rtl/ahb_matrix_pkg.sv
// Shared AHB bus-matrix definitions: HTRANS/HRESP encodings, default-slave
// state encoding and the port-index width helper.
package ahb_matrix_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    // One extra index is reserved for the default slave.
    function automatic int port_idx_width(input int num_ports);
        return $clog2(num_ports + 1);
    endfunction

endpackage

// File: rtl/ahb_matrix_decoder_np_if.sv
// Bus-side signal bundle of one decoder instance: input-stage address/response
// signals, output-stage fan-out/fan-in vectors and the decode-error capture port.
interface ahb_matrix_decoder_np_if #(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_LSB    = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int RUSER_WIDTH = 32
);
    logic                              remapping_dec;
    logic                              HREADYS;
    logic                              sel_dec;
    logic [31-ADDR_LSB:0]              decode_addr_dec;
    logic [1:0]                        trans_dec;
    logic [NUM_PORTS-1:0]              active_dec_i;
    logic [NUM_PORTS-1:0]              readyout_dec_i;
    logic [2*NUM_PORTS-1:0]            resp_dec_i;
    logic [DATA_WIDTH*NUM_PORTS-1:0]   rdata_dec_i;
    logic [RUSER_WIDTH*NUM_PORTS-1:0]  ruser_dec_i;
    logic [NUM_PORTS-1:0]              sel_dec_o;
    logic                              active_dec;
    logic                              HREADYOUTS;
    logic [1:0]                        HRESPS;
    logic [DATA_WIDTH-1:0]             HRDATAS;
    logic [RUSER_WIDTH-1:0]            HRUSERS;
    logic                              err_clr;
    logic                              err_valid;
    logic [31-ADDR_LSB:0]              err_addr;

    modport slave (
        input  remapping_dec, HREADYS, sel_dec, decode_addr_dec, trans_dec,
               active_dec_i, readyout_dec_i, resp_dec_i, rdata_dec_i, ruser_dec_i,
               err_clr,
        output sel_dec_o, active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS,
               err_valid, err_addr
    );

    modport master (
        output remapping_dec, HREADYS, sel_dec, decode_addr_dec, trans_dec,
               active_dec_i, readyout_dec_i, resp_dec_i, rdata_dec_i, ruser_dec_i,
               err_clr,
        input  sel_dec_o, active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS,
               err_valid, err_addr
    );

endinterface

// File: rtl/ahb_matrix_default_slave_np.sv
// Embedded default slave: answers unmapped NONSEQ/SEQ transfers with a
// two-cycle ERROR response and zero-wait OKAY for IDLE/BUSY.
module ahb_matrix_default_slave_np
    import ahb_matrix_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       ds_sel,
    input  logic       HREADYS,
    input  logic [1:0] trans,
    output logic       readyout,
    output logic [1:0] resp,
    output logic       err_start
);

    ds_state_t state_reg;
    ds_state_t state_next;
    logic      qualify;

    assign qualify = ds_sel && HREADYS &&
                     ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg <= DS_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        readyout   = 1'b1;
        resp       = HRESP_OKAY;
        case (state_reg)
            DS_IDLE: begin
                if (qualify) state_next = DS_ERR1;
            end
            DS_ERR1: begin
                readyout   = 1'b0;
                resp       = HRESP_ERROR;
                state_next = DS_ERR2;
            end
            DS_ERR2: begin
                resp       = HRESP_ERROR;
                state_next = qualify ? DS_ERR1 : DS_IDLE;
            end
            default: state_next = DS_IDLE;
        endcase
    end

    // Pulses in the address phase of every transfer that will receive ERROR.
    assign err_start = (state_reg != DS_ERR1) && (state_next == DS_ERR1);

endmodule

// File: rtl/ahb_matrix_decoder_np.sv
// N-output address decoder for one AHB matrix input stage with remap window,
// default slave and response mux. Optional error capture: AHB_DEC_ERR_CAPTURE_EN.
module ahb_matrix_decoder_np
    import ahb_matrix_pkg::*;
#(
    parameter int                       NUM_PORTS   = 4,
    parameter int                       ADDR_LSB    = 10,
    parameter int                       DATA_WIDTH  = 32,
    parameter int                       RUSER_WIDTH = 32,
    parameter logic [32*NUM_PORTS-1:0]  REGION_BASE = {32'h6000_0000, 32'h4000_0000,
                                                       32'h2000_0000, 32'h0000_0000},
    parameter logic [32*NUM_PORTS-1:0]  REGION_MASK = {32'hF000_0000, 32'hFFFF_0000,
                                                       32'hFFF0_0000, 32'hFFFF_8000},
    parameter logic [31:0]              REMAP_BASE  = 32'h0000_0000,
    parameter logic [31:0]              REMAP_MASK  = 32'hFFFF_8000,
    parameter int                       REMAP_PORT  = 1
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    ahb_matrix_decoder_np_if.slave  bus
);

    localparam int            AW     = 32 - ADDR_LSB;
    localparam int            PW     = port_idx_width(NUM_PORTS);
    localparam logic [PW-1:0] DS_IDX = PW'(NUM_PORTS);

    logic [NUM_PORTS-1:0] port_match;
    logic [NUM_PORTS-1:0] port_hit;
    logic [NUM_PORTS-1:0] sel_vec;
    logic                 remap_hit;
    logic [PW-1:0]        addr_port;
    logic [PW-1:0]        data_out_port_reg;
    logic                 ds_sel;
    logic                 ds_readyout;
    logic [1:0]           ds_resp;
    logic                 err_start;

    assign remap_hit = (bus.decode_addr_dec & REMAP_MASK[31:ADDR_LSB]) ==
                       REMAP_BASE[31:ADDR_LSB];

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_match[gi] =
                (bus.decode_addr_dec & REGION_MASK[gi*32+ADDR_LSB +: AW]) ==
                REGION_BASE[gi*32+ADDR_LSB +: AW];
            assign port_hit[gi] = (addr_port == PW'(gi));
            assign sel_vec[gi]  = bus.sel_dec && port_hit[gi];
        end
    endgenerate

    // Later assignments override earlier ones: remap beats idle-hold beats region match.
    always_comb begin
        addr_port = DS_IDX;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (port_match[i]) addr_port = PW'(i);
        end
        if (bus.trans_dec == HTRANS_IDLE) addr_port = data_out_port_reg;
        if (bus.remapping_dec && remap_hit) addr_port = PW'(REMAP_PORT);
    end

    assign bus.sel_dec_o  = sel_vec;
    assign bus.active_dec = (addr_port == DS_IDX) || |(port_hit & bus.active_dec_i);
    assign ds_sel         = bus.sel_dec && (addr_port == DS_IDX);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_out_port_reg <= '0;
        end else if (bus.HREADYS) begin
            data_out_port_reg <= addr_port;
        end
    end

    ahb_matrix_default_slave_np u_default_slave (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .ds_sel    (ds_sel),
        .HREADYS   (bus.HREADYS),
        .trans     (bus.trans_dec),
        .readyout  (ds_readyout),
        .resp      (ds_resp),
        .err_start (err_start)
    );

    // Default-slave values stand unless the registered port is a real output stage.
    always_comb begin
        bus.HREADYOUTS = ds_readyout;
        bus.HRESPS     = ds_resp;
        bus.HRDATAS    = '0;
        bus.HRUSERS    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (data_out_port_reg == PW'(i)) begin
                bus.HREADYOUTS = bus.readyout_dec_i[i];
                bus.HRESPS     = bus.resp_dec_i[2*i +: 2];
                bus.HRDATAS    = bus.rdata_dec_i[i*DATA_WIDTH +: DATA_WIDTH];
                bus.HRUSERS    = bus.ruser_dec_i[i*RUSER_WIDTH +: RUSER_WIDTH];
            end
        end
    end

`ifdef AHB_DEC_ERR_CAPTURE_EN
    logic          err_valid_reg;
    logic [AW-1:0] err_addr_reg;

    // A coinciding clear and new error records the new error.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_valid_reg <= 1'b0;
            err_addr_reg  <= '0;
        end else if (err_start && (!err_valid_reg || bus.err_clr)) begin
            err_valid_reg <= 1'b1;
            err_addr_reg  <= bus.decode_addr_dec;
        end else if (bus.err_clr) begin
            err_valid_reg <= 1'b0;
            err_addr_reg  <= '0;
        end
    end

    assign bus.err_valid = err_valid_reg;
    assign bus.err_addr  = err_addr_reg;
`else
    logic unused_capture;
    assign unused_capture = err_start ^ bus.err_clr;
    assign bus.err_valid  = 1'b0;
    assign bus.err_addr   = '0;
`endif

endmodule

// File: doc/ahb_matrix_decoder_np.md
# ahb_matrix_decoder_np

Parametrised N-output address decoder for one input stage of the AHB bus matrix. It maps each address-phase transfer to one of NUM_PORTS output stages or to an embedded default slave, and registers the selected port for the data phase. It multiplexes HREADYOUT, HRESP, HRDATA and HRUSER back to the input stage. It replaces the fixed single-output decoders, adding per-port regions, a priority remap window, and optional decode-error capture.

## Interface
- NUM_PORTS, 4: output stages served, 1..15
- ADDR_LSB, 10: lowest decoded address bit
- DATA_WIDTH, 32: HRDATA width
- RUSER_WIDTH, 32: HRUSER width
- REGION_BASE, {0x6000_0000, 0x4000_0000, 0x2000_0000, 0x0000_0000}: packed 32-bit base per port, port 0 in LSBs
- REGION_MASK, {0xF000_0000, 0xFFFF_0000, 0xFFF0_0000, 0xFFFF_8000}: packed 32-bit match mask per port
- REMAP_BASE, 0x0000_0000 / REMAP_MASK, 0xFFFF_8000 / REMAP_PORT, 1: remap window and its target port
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- remapping_dec  in  1  remap enable
- HREADYS  in  1  input-stage HREADY
- sel_dec  in  1  HSEL from input stage
- decode_addr_dec  in  32-ADDR_LSB  HADDR[31:ADDR_LSB]
- trans_dec  in  2  HTRANS
- active_dec_i  in  NUM_PORTS  output-stage active flags
- readyout_dec_i  in  NUM_PORTS  output-stage HREADYOUT
- resp_dec_i  in  2*NUM_PORTS  output-stage HRESP
- rdata_dec_i  in  DATA_WIDTH*NUM_PORTS  output-stage HRDATA
- ruser_dec_i  in  RUSER_WIDTH*NUM_PORTS  output-stage HRUSER
- sel_dec_o  out  NUM_PORTS  per-port HSEL
- active_dec  out  1  active flag of the addressed target
- HREADYOUTS / HRESPS / HRDATAS / HRUSERS  out  1 / 2 / DATA_WIDTH / RUSER_WIDTH  data-phase response
- err_clr  in  1  clears error capture (macro only)
- err_valid  out  1  sticky decode-error flag (macro only)
- err_addr  out  32-ADDR_LSB  captured address (macro only)

## Operation
- Port index width: PW = clog2(NUM_PORTS+1). Index NUM_PORTS denotes the default slave (DS).
- Port i matches when (addr & MASK_i[31:ADDR_LSB]) == BASE_i[31:ADDR_LSB].
- Address decode priority, combinational:
  - If remapping_dec=1 and the address is in the remap window, the target is REMAP_PORT.
  - Else, if trans_dec is IDLE (00), the target holds data_out_port (no switching on idle).
  - Else, the lowest-index matching port wins.
  - Else, the target is DS.
- sel_dec_o[addr_port] = sel_dec. All other selects are 0. DS select is internal.
- active_dec = active_dec_i[addr_port]. It is 1 when the target is DS.
- data_out_port register: loads addr_port when HREADYS=1 and holds otherwise. Reset value is 0.
- Data-phase muxing by data_out_port. For DS, HRDATAS and HRUSERS are all-zero.
- DS FSM, states IDLE, ERR1, ERR2:
  - IDLE→ERR1 when DS is selected, HREADYS=1 and trans is NONSEQ or SEQ.
  - ERR1→ERR2 unconditionally.
  - ERR2→IDLE, or →ERR1 on a new qualifying transfer.
- DS outputs per state:
  - IDLE: HREADYOUT=1, HRESP=OKAY (00).
  - ERR1: HREADYOUT=0, HRESP=ERROR (01).
  - ERR2: HREADYOUT=1, HRESP=ERROR.
- DS IDLE/BUSY transfers get a zero-wait OKAY.

## Timing
- Address phase to sel_dec_o and active_dec: combinational, 0 cycles.
- Data phase begins the cycle after HREADYS=1.
- Response mux: combinational from registered data_out_port.
- DS error response: exactly 2 data-phase cycles.
- Reset values:
  - data_out_port=0, DS=IDLE.
  - HREADYOUTS and HRESPS follow readyout_dec_i[0] and resp_dec_i[1:0].
  - err_valid=0, err_addr=0.
- Reset asserted mid-error: DS returns to IDLE immediately. No residual ERROR response after reset.
- HREADYS=0 during an address phase: data_out_port holds, and the pending decode is re-evaluated every cycle.

## Configuration
- AHB_DEC_ERR_CAPTURE_EN defined:
  - On the first IDLE→ERR1 transition with err_valid=0, err_valid is set and the address is latched into err_addr.
  - Later errors do not overwrite the captured address.
  - err_clr=1 clears both registers next cycle. If clear and a new error coincide, capture wins.
- AHB_DEC_ERR_CAPTURE_EN undefined: err_clr is ignored, and err_valid and err_addr are tied to 0.

## Structure
- Shared package ahb_matrix_pkg holds:
  - HTRANS constants IDLE/BUSY/NONSEQ/SEQ.
  - HRESP constants OKAY/ERROR.
  - The DS state enum.
  - The port-index width function.
- One sub-module: ahb_matrix_default_slave_np, containing the DS FSM.
- Decode and mux logic stay in the top module.

## Test plan
- NONSEQ to 0x2000_0400, HREADYS=1 → sel_dec_o=0010. Next cycle HRDATAS=rdata_dec_i port 1.
- NONSEQ to 0x8000_0000 → no sel_dec_o. Data phase: HREADYOUTS=0/HRESP=01, then HREADYOUTS=1/HRESP=01. Then IDLE gives OKAY.
- remapping_dec=1, NONSEQ to 0x0000_1000 → sel_dec_o=0010. With remapping_dec=0 → sel_dec_o=0001.
- Port 1 stalls with readyout_dec_i[1]=0 for 3 cycles → data_out_port is held, HREADYOUTS=0 for 3 cycles, and a new address to port 2 is not committed until HREADYS=1.
- HRESETn pulsed low during ERR1 → next cycles HREADYOUTS=readyout_dec_i[0] and HRESPS=resp_dec_i[1:0]. No ERR2 occurs.
- With AHB_DEC_ERR_CAPTURE_EN: errors at 0x8000_0000 then 0x9000_0000 → err_addr holds 0x8000_0000's bits. Then err_clr=1 → err_valid=0 next cycle.
